// File: rtl/dcntr8_pkg.sv
// Shared constants for the dcntr8 loadable down-counter/timer.
package dcntr8_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'b000;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'b001;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'b010;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'b011;
  localparam logic [STATE_W-1:0] ST_ZERO  = 3'b100;

endpackage

// File: rtl/dcntr8_ns_logic.sv
// Combinational next-state, next-count, reload and terminal-count logic for dcntr8.
module dcntr8_ns_logic
  import dcntr8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [STATE_W-1:0] state_q,
  input  logic [WIDTH-1:0]   cnt_q,
  input  logic [WIDTH-1:0]   rld_q,
  input  logic               load,
  input  logic               dec,
  input  logic               reload_en,
  input  logic [WIDTH-1:0]   d_in,
  output logic [STATE_W-1:0] state_d,
  output logic [WIDTH-1:0]   cnt_d,
  output logic [WIDTH-1:0]   rld_d,
  output logic               tc_d
);

  logic cnt_zero;
  logic cnt_one;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_one  = (cnt_q == WIDTH'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;

    if (load) begin
      cnt_d   = d_in;
      rld_d   = d_in;
      state_d = ST_LOAD;
    end else if (dec) begin
      if (!cnt_zero) begin
        // tc fires only on a genuine 1->0 step, never on load or reload
        cnt_d   = cnt_q - WIDTH'(1);
        state_d = cnt_one ? ST_ZERO : ST_RUN;
        tc_d    = cnt_one;
      end else if (reload_en && (rld_q != '0)) begin
        cnt_d   = rld_q;
        state_d = ST_RUN;
      end else begin
        state_d = ST_ZERO;
      end
    end else begin
      case (state_q)
        ST_IDLE:                         state_d = ST_IDLE;
        ST_LOAD, ST_RUN, ST_PAUSE, ST_ZERO: state_d = cnt_zero ? ST_ZERO : ST_PAUSE;
        default:                         state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dcntr8.sv
// Loadable down-counter/timer with optional auto-reload and a one-cycle terminal-count pulse.
module dcntr8
  import dcntr8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  input  logic               reload_en,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   d_out,
  output logic               tc,
  output logic [STATE_W-1:0] o_state
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rld_q, rld_d;
  logic               tc_q, tc_d;

  dcntr8_ns_logic #(
    .WIDTH (WIDTH)
  ) u_ns_logic (
    .state_q   (state_q),
    .cnt_q     (cnt_q),
    .rld_q     (rld_q),
    .load      (load),
    .dec       (dec),
    .reload_en (reload_en),
    .d_in      (d_in),
    .state_d   (state_d),
    .cnt_d     (cnt_d),
    .rld_d     (rld_d),
    .tc_d      (tc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  assign d_out   = cnt_q;
  assign tc      = tc_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_dcntr8.sv
// Self-checking bench for dcntr8: per-cycle model comparison plus directed literal checks.
module tb_dcntr8;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       dec;
  logic       reload_en;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       tc;
  logic [2:0] o_state;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int m_cnt, m_rld, m_state, m_tc;

  dcntr8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .dec       (dec),
    .reload_en (reload_en),
    .d_in      (d_in),
    .d_out     (d_out),
    .tc        (tc),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: plain integer arithmetic on the documented rules
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_rld = 0; m_state = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (load) begin
        m_cnt = int'(d_in); m_rld = int'(d_in); m_state = 1;
      end else if (dec && m_cnt > 0) begin
        m_tc    = (m_cnt == 1) ? 1 : 0;
        m_cnt   = m_cnt - 1;
        m_state = (m_cnt == 0) ? 4 : 2;
      end else if (dec) begin
        if (reload_en && m_rld > 0) begin
          m_cnt = m_rld; m_state = 2;
        end else begin
          m_state = 4;
        end
      end else if (m_state != 0) begin
        m_state = (m_cnt == 0) ? 4 : 3;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_d_out", 32'(d_out), 32'(m_cnt));
      chk("model_state", 32'(o_state), 32'(m_state));
      chk("model_tc", 32'(tc), 32'(m_tc));
    end
  end

  task automatic drive(input logic l, input logic dc, input logic re, input logic [7:0] d);
    load = l; dec = dc; reload_en = re; d_in = d;
    @(negedge clk);
  endtask

  task automatic expect3(input string nm, input logic [7:0] ed, input logic [2:0] es, input logic et);
    chk({nm, "_d_out"}, 32'(d_out), 32'(ed));
    chk({nm, "_state"}, 32'(o_state), 32'(es));
    chk({nm, "_tc"}, 32'(tc), 32'(et));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int tcs;
    reset = 1'b1; load = 1'b0; dec = 1'b0; reload_en = 1'b0; d_in = 8'h00;
    repeat (2) @(negedge clk);
    expect3("reset_init", 8'h00, 3'b000, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    drive(0, 0, 0, 8'h00);
    expect3("idle_after_reset", 8'h00, 3'b000, 1'b0);

    // Load and count 3,2,1,0
    drive(1, 0, 0, 8'h03);
    expect3("ld3", 8'h03, 3'b001, 1'b0);
    drive(0, 1, 0, 8'h00);
    expect3("cnt2", 8'h02, 3'b010, 1'b0);
    drive(0, 1, 0, 8'h00);
    expect3("cnt1", 8'h01, 3'b010, 1'b0);
    drive(0, 1, 0, 8'h00);
    expect3("cnt0", 8'h00, 3'b100, 1'b1);
    drive(0, 1, 0, 8'h00);
    expect3("hold0", 8'h00, 3'b100, 1'b0);
    drive(0, 1, 0, 8'h00);
    expect3("hold0b", 8'h00, 3'b100, 1'b0);

    // Pause and resume
    drive(1, 0, 0, 8'h2C);
    repeat (4) drive(0, 1, 0, 8'h00);
    expect3("pre_pause", 8'h28, 3'b010, 1'b0);
    drive(0, 0, 0, 8'h00);
    expect3("pause", 8'h28, 3'b011, 1'b0);
    drive(0, 0, 0, 8'h00);
    expect3("pause2", 8'h28, 3'b011, 1'b0);
    drive(0, 1, 0, 8'h00);
    expect3("resume", 8'h27, 3'b010, 1'b0);

    // Auto-reload with period 3
    drive(1, 0, 1, 8'h02);
    expect3("rl_ld", 8'h02, 3'b001, 1'b0);
    tcs = 0;
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 1, 8'h00);
      if (tc) tcs++;
      if (i == 1) expect3("rl_zero", 8'h00, 3'b100, 1'b1);
      if (i == 2) expect3("rl_reload", 8'h02, 3'b010, 1'b0);
    end
    chk("rl_tc_count", 32'(tcs), 32'd3);

    // Load wins over a 1->0 step
    drive(1, 0, 0, 8'h01);
    drive(1, 1, 0, 8'h40);
    expect3("ld_over_dec", 8'h40, 3'b001, 1'b0);

    // Loading zero with reload enabled never pulses tc
    drive(1, 0, 1, 8'h00);
    expect3("ld0", 8'h00, 3'b001, 1'b0);
    tcs = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 8'h00);
      if (tc) tcs++;
    end
    expect3("ld0_run", 8'h00, 3'b100, 1'b0);
    chk("ld0_tc_count", 32'(tcs), 32'd0);

    // Full range from FF
    drive(1, 0, 0, 8'hFF);
    tcs = 0;
    for (int i = 0; i < 255; i++) begin
      drive(0, 1, 0, 8'h00);
      if (tc) tcs++;
      if (i == 253) chk("full_last1", 32'(d_out), 32'h01);
    end
    expect3("full_end", 8'h00, 3'b100, 1'b1);
    chk("full_tc_count", 32'(tcs), 32'd1);
    drive(0, 1, 0, 8'h00);
    expect3("full_nowrap", 8'h00, 3'b100, 1'b0);

    // Asynchronous reset mid-count
    drive(1, 0, 0, 8'h08);
    repeat (3) drive(0, 1, 0, 8'h00);
    expect3("pre_reset", 8'h05, 3'b010, 1'b0);
    #2 reset = 1'b1;
    #1 expect3("async_reset", 8'h00, 3'b000, 1'b0);
    @(negedge clk);
    expect3("reset_held", 8'h00, 3'b000, 1'b0);
    reset = 1'b0;
    drive(0, 0, 0, 8'h00);
    expect3("post_reset", 8'h00, 3'b000, 1'b0);
    drive(0, 1, 0, 8'h00);
    expect3("post_reset_dec", 8'h00, 3'b100, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
